nibble_addsub_seq: RTL and testbench
====================================

# nibble_addsub_seq

Multi-cycle wide adder/subtractor controller that sequences one 4-bit adder-subtractor slice over NIBBLES nibbles, least-significant first. The carry is chained through a register between nibbles. It accepts operands with a start/busy/done handshake and holds the full-width result, carry and optional signed-overflow flag until the next operation. It sits between a requesting control unit and the shared 4-bit add/sub datapath, trading latency for area.

## Interface
- NIBBLES, 4: operand width in nibbles; W = 4*NIBBLES; legal range 2..16.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE or DONE.
- sub  input  1  0 = A+B, 1 = A−B; latched with operands.
- a  input  W  operand A (unsigned or two's complement).
- b  input  W  operand B.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse when result is updated.
- result  output  W  registered sum/difference; holds until next completion.
- carry_out  output  1  carry out of MSB; for subtraction 1 = no borrow (a ≥ b unsigned).
- overflow  output  1  signed overflow of last operation (see Configuration).

## Operation
- Nibble slice function: {c, s[3:0]} = a_n + (b_n ^ {4{sub_r}}) + cin.
  - cin = sub_r on nibble 0, registered carry on later nibbles.
- FSM states:
  - IDLE: busy=0, done=0. start=1 → latch a, b, sub; clear nibble index and work register; go to RUN.
  - RUN: busy=1. Each cycle processes nibble[idx], writes s into work register slice idx, registers c, and increments idx.
    - When idx = NIBBLES−1: load result, carry_out and overflow from work register / final carry, then go to DONE.
  - DONE: done=1, busy=0.
    - start=1 → latch new operands, go to RUN (back-to-back).
    - Otherwise go to IDLE.
- start while in RUN is ignored; operand changes while in RUN have no effect.
- result, carry_out and overflow change only on the RUN→DONE transition; partial sums are never visible.
- Width rules: all nibble arithmetic is mod 16. The final carry is the carry out of nibble NIBBLES−1. No saturation.

## Timing
- Reset (async assert, sync release): state=IDLE, busy=0, done=0, result=0, carry_out=0, overflow=0, idx=0, carry reg=0.
- Reset mid-operation aborts immediately: no done pulse; outputs return to 0.
- Latency: start sampled at edge k → busy high after edge k through edge k+NIBBLES → done high for exactly the cycle after edge k+NIBBLES, with result valid in that same cycle.
- Throughput:
  - Back-to-back (start held or re-asserted in DONE): one result every NIBBLES+1 cycles.
  - Via IDLE: one result every NIBBLES+2 cycles.
- done and busy are never high simultaneously.

## Configuration
- ADDSUB_OVF_EN defined:
  - overflow = carry into MSB XOR carry out of MSB of the final nibble.
  - The slice exposes the bit-2→bit-3 carry for this purpose.
  - overflow is registered alongside result.
- ADDSUB_OVF_EN undefined:
  - overflow tied to 0.
  - MSB-internal carry logic removed.
  - All other behaviour identical.

## Test plan (NIBBLES=4)
- Reset: assert rst_n=0 mid-RUN → busy=0, done=0, result=0x0000, carry_out=0; no done pulse after release.
- Add: a=0x1234, b=0x0FCD, sub=0 → done 4 cycles after start; result=0x2201, carry_out=0, overflow=0.
- Carry wrap: a=0xFFFF, b=0x0001, sub=0 → result=0x0000, carry_out=1, overflow=0.
- Borrow: a=0x0005, b=0x0007, sub=1 → result=0xFFFE, carry_out=0, overflow=0.
- Signed overflow:
  - a=0x7FFF, b=0x0001, sub=0 → result=0x8000, overflow=1 (0 with ADDSUB_OVF_EN undefined).
  - Then back-to-back a=0x8000, b=0x0001, sub=1 with start held in DONE → result=0x7FFF, carry_out=1, overflow=1, done spacing exactly 5 cycles.
- Ignore-while-busy: pulse start with new operands during RUN → no effect; first result unchanged; only one done pulse.

Source files
------------

// File: rtl/nibble_addsub_seq.sv
// Wide add/subtract sequenced over one shared 4-bit slice, least-significant nibble first.
// Optional signed-overflow flag is built only when ADDSUB_OVF_EN is defined.
module nibble_addsub_seq #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 sub,
  input  logic [4*NIBBLES-1:0] a,
  input  logic [4*NIBBLES-1:0] b,
  output logic                 busy,
  output logic                 done,
  output logic [4*NIBBLES-1:0] result,
  output logic                 carry_out,
  output logic                 overflow
);

  localparam int W  = 4 * NIBBLES;
  localparam int IW = $clog2(NIBBLES);
  localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;
  logic            sub_q;
  logic [IW-1:0]   idx;
  logic [W-1:0]    work;
  logic            carry;

  logic [3:0]      a_nib;
  logic [3:0]      b_nib;
  logic [3:0]      s_nib;
  logic            cin;
  logic            c_nib;
  logic            ovf_next;
  logic [W-1:0]    work_next;

  // Shared 4-bit slice on the current nibble, plus the work register with that nibble merged in
  always_comb begin
    a_nib = a_q[{idx, 2'b00} +: 4];
    b_nib = b_q[{idx, 2'b00} +: 4] ^ {4{sub_q}};
    if (idx == {IW{1'b0}}) begin
      cin = sub_q;
    end else begin
      cin = carry;
    end
    {c_nib, s_nib} = {1'b0, a_nib} + {1'b0, b_nib} + {4'b0000, cin};
    work_next = work;
    work_next[{idx, 2'b00} +: 4] = s_nib;
  end

`ifdef ADDSUB_OVF_EN
  logic [3:0] low_sum;

  // Carry into the slice MSB, compared against the carry out for signed overflow
  always_comb begin
    low_sum  = {1'b0, a_nib[2:0]} + {1'b0, b_nib[2:0]} + {3'b000, cin};
    ovf_next = low_sum[3] ^ c_nib;
  end
`else
  assign ovf_next = 1'b0;
`endif

  // Control FSM; all outputs registered, result fields updated only on RUN->DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      a_q       <= {W{1'b0}};
      b_q       <= {W{1'b0}};
      sub_q     <= 1'b0;
      idx       <= {IW{1'b0}};
      work      <= {W{1'b0}};
      carry     <= 1'b0;
      result    <= {W{1'b0}};
      carry_out <= 1'b0;
      overflow  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            a_q   <= a;
            b_q   <= b;
            sub_q <= sub;
            idx   <= {IW{1'b0}};
            work  <= {W{1'b0}};
            carry <= 1'b0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        RUN: begin
          work  <= work_next;
          carry <= c_nib;
          if (idx == LAST_IDX) begin
            result    <= work_next;
            carry_out <= c_nib;
            overflow  <= ovf_next;
            idx       <= {IW{1'b0}};
            busy      <= 1'b0;
            done      <= 1'b1;
            state     <= DONE;
          end else begin
            idx   <= idx + 1'b1;
            busy  <= 1'b1;
            done  <= 1'b0;
            state <= RUN;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          idx   <= {IW{1'b0}};
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_addsub_seq.sv
// Directed self-checking bench for nibble_addsub_seq with NIBBLES=4.
// Overflow expectations follow ADDSUB_OVF_EN.
module tb_nibble_addsub_seq;

  localparam int N = 4;
  localparam int W = 4 * N;

`ifdef ADDSUB_OVF_EN
  localparam logic OVF_ON = 1'b1;
`else
  localparam logic OVF_ON = 1'b0;
`endif

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         carry_out;
  logic         overflow;

  int vectors;
  int miscompares;

  nibble_addsub_seq #(.NIBBLES(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .sub       (sub),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .carry_out (carry_out),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for done; returns the number of negedges seen since entry plus 'base'
  task automatic wait_done(input int base, output int lat, output logic overlap);
    lat = base;
    overlap = 1'b0;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
      if (busy && done) overlap = 1'b1;
    end
  endtask

  // One operation from IDLE: start pulsed for one cycle, then result and latency checked
  task automatic run_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic sv, input logic [W-1:0] er, input logic ec, input logic eo);
    int lat;
    logic ov;
    @(negedge clk);
    a = av; b = bv; sub = sv; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = ~av; b = ~bv; sub = ~sv;
    chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
    wait_done(1, lat, ov);
    chk({tag, "_lat"}, lat, N + 1);
    chk({tag, "_res"}, {16'd0, result}, {16'd0, er});
    chk({tag, "_cout"}, {31'd0, carry_out}, {31'd0, ec});
    chk({tag, "_ovf"}, {31'd0, overflow}, {31'd0, eo});
    chk({tag, "_nobusy"}, {31'd0, busy | ov}, 32'd0);
    @(negedge clk);
    chk({tag, "_pulse"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    int lat;
    int dcount;
    logic ov;
    vectors = 0;
    miscompares = 0;
    rst_n = 1'b0; start = 1'b0; sub = 1'b0; a = '0; b = '0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_res", {16'd0, result}, 32'd0);
    chk("rst_cout", {31'd0, carry_out}, 32'd0);
    chk("rst_ovf", {31'd0, overflow}, 32'd0);
    rst_n = 1'b1;

    run_op("add", 16'h1234, 16'h0FCD, 1'b0, 16'h2201, 1'b0, 1'b0);
    run_op("wrap", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_op("borrow", 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0);

    // Signed overflow, then back-to-back subtract with start held through DONE
    @(negedge clk);
    a = 16'h7FFF; b = 16'h0001; sub = 1'b0; start = 1'b1;
    @(negedge clk);
    a = 16'h8000; b = 16'h0001; sub = 1'b1;
    wait_done(1, lat, ov);
    chk("ovf_lat", lat, N + 1);
    chk("ovf_res", {16'd0, result}, 32'h0000_8000);
    chk("ovf_cout", {31'd0, carry_out}, 32'd0);
    chk("ovf_ovf", {31'd0, overflow}, {31'd0, OVF_ON});
    @(negedge clk);
    start = 1'b0;
    chk("b2b_busy", {31'd0, busy}, 32'd1);
    wait_done(1, lat, ov);
    chk("b2b_spacing", lat, N + 1);
    chk("b2b_res", {16'd0, result}, 32'h0000_7FFF);
    chk("b2b_cout", {31'd0, carry_out}, 32'd1);
    chk("b2b_ovf", {31'd0, overflow}, {31'd0, OVF_ON});
    chk("b2b_overlap", {31'd0, ov}, 32'd0);
    @(negedge clk);

    // Start pulse with fresh operands during RUN must be ignored
    @(negedge clk);
    a = 16'h1111; b = 16'h2222; sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    a = 16'hAAAA; b = 16'h5555; sub = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(3, lat, ov);
    chk("ign_lat", lat, N + 1);
    chk("ign_res", {16'd0, result}, 32'h0000_3333);
    chk("ign_cout", {31'd0, carry_out}, 32'd0);
    dcount = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) dcount++;
    end
    chk("ign_single_done", dcount, 0);

    // Reset asserted mid-RUN aborts and clears outputs
    @(negedge clk);
    a = 16'h4321; b = 16'h1111; sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_done", {31'd0, done}, 32'd0);
    chk("mid_rst_res", {16'd0, result}, 32'd0);
    chk("mid_rst_cout", {31'd0, carry_out}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dcount = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done || busy) dcount++;
    end
    chk("mid_rst_no_done", dcount, 0);

    run_op("post_rst", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, OVF_ON);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
